// File: rtl/viterbi_acs_ctrl_if.sv
// Handshake bundle between the Viterbi ACS frame sequencer and its BMU, ACS and traceback peers.
// master = sequencer side, slave = the surrounding datapath.
interface viterbi_acs_ctrl_if #(
    parameter int PTR_W    = 3,
    parameter int METRIC_W = 4
);
    logic                sym_valid;
    logic                sym_last;
    logic                sym_ready;
    logic                acs_valid;
    logic                acs_first;
    logic                acs_flush;
    logic                acs_done;
    logic [METRIC_W-1:0] min_metric;
    logic                norm_en;
    logic [PTR_W-1:0]    wr_ptr;
    logic                tb_start;
    logic [PTR_W-1:0]    tb_ptr;
    logic                tb_final;
    logic                tb_done;
    logic                busy;

    modport master (
        input  sym_valid, sym_last, acs_done, min_metric, tb_done,
        output sym_ready, acs_valid, acs_first, acs_flush, norm_en,
               wr_ptr, tb_start, tb_ptr, tb_final, busy
    );

    modport slave (
        output sym_valid, sym_last, acs_done, min_metric, tb_done,
        input  sym_ready, acs_valid, acs_first, acs_flush, norm_en,
               wr_ptr, tb_start, tb_ptr, tb_final, busy
    );
endinterface

// File: rtl/viterbi_acs_ctrl.sv
// Frame sequencer for the 4-state Viterbi ACS: startup/steady/tail strobes, survivor pointer,
// sliding and final traceback launch. Define VITERBI_CTRL_NORM_EN to enable metric normalization.
module viterbi_acs_ctrl #(
    parameter int PTR_W       = 3,
    parameter int METRIC_W    = 4,
    parameter int START_LEN   = 2,
    parameter int TAIL_LEN    = 2,
    parameter int NORM_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    viterbi_acs_ctrl_if.master    bus
);
    localparam int CNT_W = 8;
    localparam logic [PTR_W-1:0] PTR_MAX    = '1;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] TAIL_N     = CNT_W'(TAIL_LEN);

    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_FLUSH, S_TB_FINAL} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   start_cnt_reg, start_cnt_next;
    logic [CNT_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic               outstanding_reg, outstanding_next;
    logic               tb_pending_reg, tb_pending_next;
    logic               tb_sent_reg, tb_sent_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   tb_ptr_reg, tb_ptr_next;
    logic               sym_ready_reg, sym_ready_next;
    logic               acs_valid_reg, acs_valid_next;
    logic               acs_first_reg, acs_first_next;
    logic               acs_flush_reg, acs_flush_next;
    logic               tb_start_reg, tb_start_next;
    logic               tb_final_reg, tb_final_next;
    logic               busy_reg, busy_next;
    logic               norm_en_reg, norm_en_next;

    logic accept, done_ok, wrap, issue_block;

    always_comb begin
        state_next       = state_reg;
        start_cnt_next   = start_cnt_reg;
        flush_cnt_next   = flush_cnt_reg;
        outstanding_next = outstanding_reg;
        tb_sent_next     = tb_sent_reg;
        wr_ptr_next      = wr_ptr_reg;
        tb_ptr_next      = tb_ptr_reg;
        acs_valid_next   = 1'b0;
        acs_first_next   = 1'b0;
        acs_flush_next   = 1'b0;
        tb_start_next    = 1'b0;
        tb_final_next    = 1'b0;

        accept  = bus.sym_valid & sym_ready_reg;
        done_ok = bus.acs_done & outstanding_reg;
        wrap    = done_ok && (wr_ptr_reg == PTR_MAX) && (state_reg != S_TB_FINAL);
        // Writing the top address again while a window traceback is still reading would clobber it.
        issue_block = tb_pending_reg && !bus.tb_done && (wr_ptr_reg == PTR_MAX);

        if (done_ok) begin
            outstanding_next = 1'b0;
            wr_ptr_next      = wr_ptr_reg + PTR_W'(1);
        end
        if (wrap) begin
            tb_start_next = 1'b1;
            tb_ptr_next   = PTR_MAX;
        end
        tb_pending_next = (tb_pending_reg & ~bus.tb_done) | wrap;

        if (accept) begin
            acs_valid_next   = 1'b1;
            outstanding_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: if (accept) begin
                acs_first_next = 1'b1;
                start_cnt_next = CNT_W'(1);
                flush_cnt_next = '0;
                if (bus.sym_last)     state_next = S_FLUSH;
                else if (START_LEN <= 1) state_next = S_RUN;
                else                  state_next = S_START;
            end
            S_START: if (accept) begin
                acs_first_next = 1'b1;
                start_cnt_next = start_cnt_reg + CNT_W'(1);
                if (bus.sym_last)                   state_next = S_FLUSH;
                else if (start_cnt_reg >= START_LAST) state_next = S_RUN;
            end
            S_RUN: if (accept && bus.sym_last) state_next = S_FLUSH;
            S_FLUSH: begin
                if (!outstanding_reg && (flush_cnt_reg < TAIL_N) && !issue_block) begin
                    acs_valid_next   = 1'b1;
                    acs_flush_next   = 1'b1;
                    outstanding_next = 1'b1;
                    flush_cnt_next   = flush_cnt_reg + CNT_W'(1);
                end else if (done_ok && (flush_cnt_reg == TAIL_N)) begin
                    state_next   = S_TB_FINAL;
                    tb_sent_next = 1'b0;
                end
            end
            S_TB_FINAL: begin
                // A still-running window traceback must finish before the final one is launched.
                if (!tb_sent_reg) begin
                    if (!tb_pending_reg || bus.tb_done) begin
                        tb_start_next = 1'b1;
                        tb_final_next = 1'b1;
                        tb_ptr_next   = wr_ptr_reg - PTR_W'(1);
                        tb_sent_next  = 1'b1;
                    end
                end else if (bus.tb_done) begin
                    state_next   = S_IDLE;
                    wr_ptr_next  = '0;
                    tb_sent_next = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        sym_ready_next = ((state_next == S_IDLE) || (state_next == S_START) || (state_next == S_RUN))
                         && !outstanding_next && !(tb_pending_next && (wr_ptr_next == PTR_MAX));
        busy_next = (state_next != S_IDLE);

`ifdef VITERBI_CTRL_NORM_EN
        norm_en_next = norm_en_reg;
        if (acs_valid_reg) norm_en_next = 1'b0;
        if (done_ok && (bus.min_metric >= METRIC_W'(NORM_THRESH))) norm_en_next = 1'b1;
`else
        norm_en_next = 1'b0;
`endif
    end

`ifndef VITERBI_CTRL_NORM_EN
    logic unused_norm;
    assign unused_norm = ^{bus.min_metric, NORM_THRESH[0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            start_cnt_reg   <= '0;
            flush_cnt_reg   <= '0;
            outstanding_reg <= 1'b0;
            tb_pending_reg  <= 1'b0;
            tb_sent_reg     <= 1'b0;
            wr_ptr_reg      <= '0;
            tb_ptr_reg      <= '0;
            sym_ready_reg   <= 1'b0;
            acs_valid_reg   <= 1'b0;
            acs_first_reg   <= 1'b0;
            acs_flush_reg   <= 1'b0;
            tb_start_reg    <= 1'b0;
            tb_final_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            norm_en_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            start_cnt_reg   <= start_cnt_next;
            flush_cnt_reg   <= flush_cnt_next;
            outstanding_reg <= outstanding_next;
            tb_pending_reg  <= tb_pending_next;
            tb_sent_reg     <= tb_sent_next;
            wr_ptr_reg      <= wr_ptr_next;
            tb_ptr_reg      <= tb_ptr_next;
            sym_ready_reg   <= sym_ready_next;
            acs_valid_reg   <= acs_valid_next;
            acs_first_reg   <= acs_first_next;
            acs_flush_reg   <= acs_flush_next;
            tb_start_reg    <= tb_start_next;
            tb_final_reg    <= tb_final_next;
            busy_reg        <= busy_next;
            norm_en_reg     <= norm_en_next;
        end
    end

    assign bus.sym_ready = sym_ready_reg;
    assign bus.acs_valid = acs_valid_reg;
    assign bus.acs_first = acs_first_reg;
    assign bus.acs_flush = acs_flush_reg;
    assign bus.norm_en   = norm_en_reg;
    assign bus.wr_ptr    = wr_ptr_reg;
    assign bus.tb_start  = tb_start_reg;
    assign bus.tb_ptr    = tb_ptr_reg;
    assign bus.tb_final  = tb_final_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Directed bench for viterbi_acs_ctrl: frames of various lengths with modelled ACS and traceback peers.
module tb_viterbi_acs_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_acs_ctrl_if #(.PTR_W(3), .METRIC_W(4)) bus();

    viterbi_acs_ctrl #(
        .PTR_W(3), .METRIC_W(4), .START_LEN(2), .TAIL_LEN(2), .NORM_THRESH(12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-frame observation log
    int          n_strobe;
    logic [31:0] first_bits, flush_bits, norm_bits;
    int          n_tb;
    int          tb_ptr_log[8];
    int          tb_fin_log[8];
    int          acc16_cyc, tbdone1_cyc, done_at_tbdone1;
    logic [31:0] finished;

    task automatic run_frame(input int nsym, input int tb_lat, input int first_tb_lat,
                             input int abort_ptr, input bit norm_test);
        int sent = 0, cyc = 0, acs_t = -1, tb_t = -1, n_done = 0;
        bit acc = 0, saw_final = 0, first_tb_open = 0;
        n_strobe = 0; first_bits = '0; flush_bits = '0; norm_bits = '0;
        n_tb = 0; acc16_cyc = 0; tbdone1_cyc = 0; done_at_tbdone1 = -1; finished = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1; cyc++;
            if (acc) begin
                sent++;
                if (sent == 16) acc16_cyc = cyc;
            end
            if (abort_ptr >= 0 && sent > 2 && int'(bus.wr_ptr) == abort_ptr) begin
                finished = 1;
                break;
            end
            // ACS model: answers one cycle after each strobe
            bus.acs_done = 1'b0; bus.min_metric = '0;
            if (acs_t == 0) begin
                bus.acs_done = 1'b1;
                if (norm_test && n_done == 0) bus.min_metric = 4'd13;
                if (norm_test && n_done == 1) bus.min_metric = 4'd11;
                n_done++;
                acs_t = -1;
            end
            if (bus.acs_valid) begin
                if (n_strobe < 32) begin
                    first_bits[n_strobe] = bus.acs_first;
                    flush_bits[n_strobe] = bus.acs_flush;
                    norm_bits[n_strobe]  = bus.norm_en;
                end
                n_strobe++;
                acs_t = 0;
            end
            // Traceback model
            bus.tb_done = 1'b0;
            if (tb_t == 0) begin
                bus.tb_done = 1'b1;
                if (first_tb_open) begin
                    first_tb_open = 0; tbdone1_cyc = cyc; done_at_tbdone1 = n_done;
                end
                tb_t = -1;
            end else if (tb_t > 0) begin
                tb_t--;
            end
            if (bus.tb_start) begin
                if (n_tb < 8) begin
                    tb_ptr_log[n_tb] = int'(bus.tb_ptr);
                    tb_fin_log[n_tb] = int'(bus.tb_final);
                end
                if (n_tb == 0) begin
                    first_tb_open = 1; tb_t = first_tb_lat - 1;
                end else begin
                    tb_t = tb_lat - 1;
                end
                if (bus.tb_final) saw_final = 1;
                n_tb++;
            end
            if (saw_final && !bus.busy && !bus.tb_done) begin
                finished = 1;
                break;
            end
            bus.sym_valid = (sent < nsym);
            bus.sym_last  = (sent == nsym - 1);
            acc = bus.sym_valid && bus.sym_ready;
        end
        bus.sym_valid = 0; bus.sym_last = 0; bus.acs_done = 0; bus.tb_done = 0; bus.min_metric = '0;
        check("frame_completes", finished, 1);
    endtask

    logic [31:0] exp_norm;

    initial begin
        bus.sym_valid = 0; bus.sym_last = 0; bus.acs_done = 0; bus.tb_done = 0; bus.min_metric = '0;
`ifdef VITERBI_CTRL_NORM_EN
        exp_norm = 32'd2;
`else
        exp_norm = 32'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_sym_ready", bus.sym_ready, 0);
        check("rst_acs_valid", bus.acs_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_ptr", bus.wr_ptr, 0);
        check("rst_tb_start", bus.tb_start, 0);
        check("rst_norm_en", bus.norm_en, 0);
        @(negedge clk); rst = 1;

        // 3-symbol frame, normalization metrics 13 then 11
        run_frame(3, 2, 2, -1, 1);
        $display("[TB] frame3: strobes=%0d first=%b flush=%b norm=%b tb_ptr=%0d", n_strobe,
                 first_bits[4:0], flush_bits[4:0], norm_bits[4:0], tb_ptr_log[0]);
        check("f3_strobes", n_strobe, 5);
        check("f3_first", first_bits, 32'h3);
        check("f3_flush", flush_bits, 32'h18);
        check("f3_norm", norm_bits, exp_norm);
        check("f3_n_tb", n_tb, 1);
        check("f3_tb_ptr", tb_ptr_log[0], 4);
        check("f3_tb_final", tb_fin_log[0], 1);
        check("f3_busy_after", bus.busy, 0);
        check("f3_wr_ptr_after", bus.wr_ptr, 0);

        // 20-symbol frame, prompt traceback
        run_frame(20, 2, 2, -1, 0);
        $display("[TB] frame20: strobes=%0d tbs=%0d ptrs=%0d,%0d,%0d", n_strobe, n_tb,
                 tb_ptr_log[0], tb_ptr_log[1], tb_ptr_log[2]);
        check("f20_strobes", n_strobe, 22);
        check("f20_first", first_bits, 32'h3);
        check("f20_flush", flush_bits, 32'h300000);
        check("f20_norm", norm_bits, 0);
        check("f20_n_tb", n_tb, 3);
        check("f20_tb0_ptr", tb_ptr_log[0], 7);
        check("f20_tb0_final", tb_fin_log[0], 0);
        check("f20_tb1_ptr", tb_ptr_log[1], 7);
        check("f20_tb1_final", tb_fin_log[1], 0);
        check("f20_tb2_ptr", tb_ptr_log[2], 5);
        check("f20_tb2_final", tb_fin_log[2], 1);
        check("f20_wr_ptr_after", bus.wr_ptr, 0);

        // Same frame, first traceback held for 30 cycles
        run_frame(20, 2, 30, -1, 0);
        $display("[TB] frame20_stall: acc16@%0d tbdone1@%0d writes_at_tbdone1=%0d", acc16_cyc,
                 tbdone1_cyc, done_at_tbdone1);
        check("stall_acc16_after_tbdone", (acc16_cyc > tbdone1_cyc), 1);
        check("stall_writes_held", done_at_tbdone1, 15);
        check("stall_strobes", n_strobe, 22);
        check("stall_n_tb", n_tb, 3);
        check("stall_tb1_ptr", tb_ptr_log[1], 7);
        check("stall_tb2_ptr", tb_ptr_log[2], 5);

        // Reset mid-frame once wr_ptr reaches 5
        run_frame(20, 2, 2, 5, 0);
        check("abort_wr_ptr", bus.wr_ptr, 5);
        #2; rst = 0; #1;
        $display("[TB] async reset mid-frame: busy=%0d wr_ptr=%0d ready=%0d", bus.busy, bus.wr_ptr,
                 bus.sym_ready);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_wr_ptr", bus.wr_ptr, 0);
        check("mid_rst_sym_ready", bus.sym_ready, 0);
        check("mid_rst_acs_valid", bus.acs_valid, 0);
        check("mid_rst_tb_start", bus.tb_start, 0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_tb", bus.tb_start, 0);
        @(negedge clk); rst = 1;

        // Single-symbol frame after the reset
        run_frame(1, 2, 2, -1, 0);
        $display("[TB] frame1: strobes=%0d first=%b flush=%b tb_ptr=%0d final=%0d", n_strobe,
                 first_bits[2:0], flush_bits[2:0], tb_ptr_log[0], tb_fin_log[0]);
        check("f1_strobes", n_strobe, 3);
        check("f1_first", first_bits, 32'h1);
        check("f1_flush", flush_bits, 32'h6);
        check("f1_n_tb", n_tb, 1);
        check("f1_tb_ptr", tb_ptr_log[0], 2);
        check("f1_tb_final", tb_fin_log[0], 1);
        check("f1_wr_ptr_after", bus.wr_ptr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
